// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM state codes, oversampling
// ratio and the baud divider computation.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Clock cycles per oversample tick; callers must keep the result >= 2.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, held at phase
// zero while clear is asserted so the first tick lands DIV cycles after release.
module uart_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap = (cnt_q == W'(DIV - 1));
  assign tick = wrap;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver (optional parity) with 16x oversampling, mid-bit sampling,
// start-bit glitch rejection and one-cycle result pulses.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);

  logic [1:0] sync_q;
  logic       rx_s;
  logic       rx_prev_q;
  logic       tick;
  logic       clear;

  logic [2:0] state_q,  state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q,  shift_d;
  logic       par_bad_q, par_bad_d;
  logic [7:0] data_q,   data_d;
  logic       valid_q,  valid_d;
  logic       ferr_q,   ferr_d;
  logic       perr_q,   perr_d;

  assign rx_s  = sync_q[1];
  assign clear = (state_q == ST_IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Edge-triggered so a held-low (break) line never re-arms.
        if (!rx_s && rx_prev_q) begin
          state_d   = ST_START;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_cnt_q == 4'(MID_SAMPLE - 1)) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_cnt_q == 4'(OVERSAMPLE - 1)) begin
            os_cnt_d = '0;
            shift_d  = {rx_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (os_cnt_q == 4'(OVERSAMPLE - 1)) begin
            os_cnt_d  = '0;
            par_bad_d = ((^shift_q) ^ PARITY_ODD) != rx_s;
            state_d   = ST_STOP;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (os_cnt_q == 4'(OVERSAMPLE - 1)) begin
            os_cnt_d = '0;
            state_d  = ST_IDLE;
            if (!rx_s) begin
              ferr_d = 1'b1;
            end else if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: one 8N1 instance and one even-parity instance
// at 160 clocks per bit, table-driven frames plus hand-written corner sequences.
module tb_uart_rx_frame;

  localparam int BIT_CYC = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, ferr_a, perr_a, busy_a;
  logic       valid_b, ferr_b, perr_b, busy_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid_a = 0, n_ferr_a = 0, n_perr_a = 0, n_busy_a = 0;
  int n_valid_b = 0, n_ferr_b = 0, n_perr_b = 0;
  int last_valid_cyc_a = 0;
  logic [7:0] got_a[$];

  always #5 clk = ~clk;

  uart_rx_frame #(.CLK_HZ(1600000), .BAUD(10000), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .reset(reset), .rx_in(rx_a), .data_out(data_a), .data_valid(valid_a),
    .frame_err(ferr_a), .parity_err(perr_a), .busy(busy_a)
  );

  uart_rx_frame #(.CLK_HZ(1600000), .BAUD(10000), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
    .clk(clk), .reset(reset), .rx_in(rx_b), .data_out(data_b), .data_valid(valid_b),
    .frame_err(ferr_b), .parity_err(perr_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_a) begin
      n_valid_a++;
      last_valid_cyc_a = cyc;
      got_a.push_back(data_a);
    end
    if (ferr_a) n_ferr_a++;
    if (perr_a) n_perr_a++;
    if (busy_a) n_busy_a++;
    if (valid_b) n_valid_b++;
    if (ferr_b) n_ferr_b++;
    if (perr_b) n_perr_b++;
    if (valid_a || ferr_a || perr_a)
      check("one_pulse_a", int'(valid_a) + int'(ferr_a) + int'(perr_a), 1);
    if (valid_b || ferr_b || perr_b)
      check("one_pulse_b", int'(valid_b) + int'(ferr_b) + int'(perr_b), 1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit to_par, input logic v);
    if (to_par) rx_b = v;
    else        rx_a = v;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit to_par, input bit par_bit,
                            input logic stop_bit);
    logic [7:0] d;
    d = b;
    set_rx(to_par, 1'b0);
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      set_rx(to_par, d[i]);
      wait_cyc(BIT_CYC);
    end
    if (to_par) begin
      set_rx(to_par, par_bit);
      wait_cyc(BIT_CYC);
    end
    set_rx(to_par, stop_bit);
    wait_cyc(BIT_CYC);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         to_par;
    bit         par_bit;
    logic       stop_bit;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0, p0, b0, c0, q0;

    vecs[0] = '{8'h00, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h00};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 0, 1, 0, 8'hFF};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'h07};
    vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b1, 0, 0, 1, 8'h07};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 0, 1, 0, 8'h07};

    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    check("rst_data", int'(data_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_ferr", int'(ferr_a), 0);
    check("rst_perr", int'(perr_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    wait_cyc(50);

    // Clean byte with latency and busy window.
    v0 = n_valid_a; f0 = n_ferr_a; b0 = n_busy_a; c0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_cyc(BIT_CYC);
    check("a5_valid", n_valid_a - v0, 1);
    check("a5_ferr", n_ferr_a - f0, 0);
    check("a5_data", int'(data_a), 8'hA5);
    check_range("a5_latency", last_valid_cyc_a - c0, 1518, 1538);
    check_range("a5_busy_cyc", n_busy_a - b0, 1505, 1535);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].to_par) begin
        v0 = n_valid_b; f0 = n_ferr_b; p0 = n_perr_b;
      end else begin
        v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a;
      end
      send_frame(vecs[i].data, vecs[i].to_par, vecs[i].par_bit, vecs[i].stop_bit);
      set_rx(vecs[i].to_par, 1'b1);
      wait_cyc(2 * BIT_CYC);
      if (vecs[i].to_par) begin
        check($sformatf("v%0d_valid", i), n_valid_b - v0, vecs[i].exp_valid);
        check($sformatf("v%0d_ferr", i), n_ferr_b - f0, vecs[i].exp_ferr);
        check($sformatf("v%0d_perr", i), n_perr_b - p0, vecs[i].exp_perr);
        check($sformatf("v%0d_data", i), int'(data_b), int'(vecs[i].exp_data));
      end else begin
        check($sformatf("v%0d_valid", i), n_valid_a - v0, vecs[i].exp_valid);
        check($sformatf("v%0d_ferr", i), n_ferr_a - f0, vecs[i].exp_ferr);
        check($sformatf("v%0d_perr", i), n_perr_a - p0, vecs[i].exp_perr);
        check($sformatf("v%0d_data", i), int'(data_a), int'(vecs[i].exp_data));
      end
    end

    // Back-to-back frames, one stop bit, no idle gap.
    v0 = n_valid_a; q0 = got_a.size();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_cyc(BIT_CYC);
    check("b2b_count", n_valid_a - v0, 2);
    check("b2b_first", (got_a.size() > q0) ? int'(got_a[q0]) : -1, 8'h3C);
    check("b2b_second", (got_a.size() > q0 + 1) ? int'(got_a[q0 + 1]) : -1, 8'h81);

    // Short low glitch on an idle line.
    v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a; b0 = n_busy_a;
    rx_a = 1'b0;
    wait_cyc(40);
    rx_a = 1'b1;
    wait_cyc(400);
    check("glitch_pulses", (n_valid_a - v0) + (n_ferr_a - f0) + (n_perr_a - p0), 0);
    check_range("glitch_busy_cyc", n_busy_a - b0, 1, 159);
    check("glitch_idle", int'(busy_a), 0);

    // Framing error followed by a held-low line.
    v0 = n_valid_a; f0 = n_ferr_a;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_cyc(2000);
    check("brk_ferr", n_ferr_a - f0, 1);
    check("brk_valid", n_valid_a - v0, 0);
    check("brk_data", int'(data_a), 8'h81);
    check("brk_idle", int'(busy_a), 0);
    rx_a = 1'b1;
    wait_cyc(BIT_CYC);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_cyc(BIT_CYC);
    check("brk_recover_valid", n_valid_a - v0, 1);
    check("brk_recover_data", int'(data_a), 8'h3C);

    // Reset pulse during data bit 4 of 8'hFF.
    v0 = n_valid_a; f0 = n_ferr_a; p0 = n_perr_a;
    rx_a = 1'b0;
    wait_cyc(BIT_CYC);
    rx_a = 1'b1;
    wait_cyc(4 * BIT_CYC + BIT_CYC / 2);
    check("mid_busy_before", int'(busy_a), 1);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("mid_rst_data", int'(data_a), 0);
    check("mid_rst_valid", int'(valid_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    wait_cyc(6 * BIT_CYC);
    check("mid_rst_pulses", (n_valid_a - v0) + (n_ferr_a - f0) + (n_perr_a - p0), 0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    wait_cyc(BIT_CYC);
    check("post_rst_valid", n_valid_a - v0, 1);
    check("post_rst_data", int'(data_a), 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
